// File: rtl/fifo_serial_drain.sv
// fifo_serial_drain: FIFO read-side consumer that pops bytes and sends them
// out one at a time as start/data/stop serial frames at a fixed bit rate.
module fifo_serial_drain #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
    input  logic              FIFO_EMPTY,
    input  logic [DATA_W-1:0] FIFO_DATA,
    output logic              FIFO_RD,
    output logic              TX,
    output logic              BUSY,
    output logic              BYTE_DONE
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_W + 1);

    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [IW-1:0]     r_idx;
    logic [IW-1:0]     w_idx_nxt;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] w_shreg_nxt;

    logic w_bit_end;
    logic w_tx_nxt;
    logic w_rd_nxt;
    logic w_busy_nxt;
    logic w_done_nxt;

    assign w_bit_end = (r_cnt == CNT_MAX);

    // Next state, baud counter, bit index and shift register
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shreg_nxt = r_shreg;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (EN && !FIFO_EMPTY) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_shreg_nxt = FIFO_DATA;
                w_idx_nxt   = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_START;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_shreg_nxt = r_shreg >> 1;
                    if (r_idx == IDX_MAX) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Output values for the upcoming state, so the pins are plain flops
    always_comb begin
        w_tx_nxt   = 1'b1;
        w_rd_nxt   = (w_state_nxt == S_REQ);
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_STOP) && (w_cnt_nxt == CNT_MAX);
        if (w_state_nxt == S_START) begin
            w_tx_nxt = 1'b0;
        end else if (w_state_nxt == S_DATA) begin
            w_tx_nxt = w_shreg_nxt[0];
        end
    end

    // State and datapath registers; reset abandons any frame in flight
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shreg <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shreg <= w_shreg_nxt;
        end
    end

    // Registered outputs; line returns high at once on reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            TX        <= 1'b1;
            FIFO_RD   <= 1'b0;
            BUSY      <= 1'b0;
            BYTE_DONE <= 1'b0;
        end else begin
            TX        <= w_tx_nxt;
            FIFO_RD   <= w_rd_nxt;
            BUSY      <= w_busy_nxt;
            BYTE_DONE <= w_done_nxt;
        end
    end

endmodule
